// File: rtl/rv_pkg.sv
// +--------------------------------------------------------------------+
// | rv_pkg : shared RV32I front-end types and constants                |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package rv_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// +--------------------------------------------------------------------+
// | fetch_fifo : synchronous FIFO of fetch packets with flush          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module fetch_fifo
  import rv_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push,
  input  fetch_pkt_t                         push_data,
  input  logic                               pop,
  input  logic                               flush,
  output logic                               full,
  output logic                               empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
  output fetch_pkt_t                         head
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  fetch_pkt_t       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Depth is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// +--------------------------------------------------------------------+
// | fetch_unit : RV32I fetch stage (PC, imem address, packet FIFO)     |
// | Optional macro FETCH_PERF_EN adds perf_fetched / perf_stall.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc_plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0]  pc;
  logic             deq;
  logic             enq;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fetch_pkt_t       fifo_head;
  fetch_pkt_t       fifo_in;

  assign imem_addr = pc;
  assign deq       = out_valid && out_ready;
  // A dequeue frees a slot in the same cycle, so a full FIFO still accepts.
  assign enq       = !redirect_valid && (!fifo_full || deq);
  assign fifo_in   = '{pc: pc, instr: imem_instr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[XLEN-1:2], 2'b00};
    end else if (enq) begin
      pc <= pc + 32'd4;
    end
  end

  fetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (enq),
    .push_data (fifo_in),
    .pop       (deq),
    .flush     (redirect_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign out_valid    = (fifo_count != '0);
  assign out_pc       = fifo_empty ? '0 : fifo_head.pc;
  assign out_instr    = fifo_empty ? INSTR_NOP : fifo_head.instr;
  assign out_pc_plus4 = out_pc + 32'd4;

`ifdef FETCH_PERF_EN
  logic stall;
  assign stall = !redirect_valid && fifo_full && !deq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (enq) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (stall) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire
